// File: rtl/reg_dump_ctrl_pkg.sv
// reg_dump_ctrl_pkg: widths, register count and FSM states for reg_dump_ctrl (CSUM exists only with REG_DUMP_CHECKSUM_EN)
package reg_dump_ctrl_pkg;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 3;
  localparam int NUM_REGS = 8;
  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;
endpackage

// File: rtl/reg_dump_ctrl_if.sv
// reg_dump_ctrl_if: register read port plus streaming valid/ready output of the dump controller
interface reg_dump_ctrl_if;
  import reg_dump_ctrl_pkg::*;
  logic start;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport master (
    input start, rd_data, out_ready,
    output busy, done, rd_addr, out_data, out_valid, out_last
  );
  modport slave (
    output start, rd_data, out_ready,
    input busy, done, rd_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: walks read port 1 over r0..r(NUM_REGS-1) and streams each word; REG_DUMP_CHECKSUM_EN appends a sum word
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
(
  input logic clk,
  input logic reset,
  reg_dump_ctrl_if.master bus
);
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic hs;
  logic last_idx;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif
  assign hs = bus.out_valid && bus.out_ready;
  assign last_idx = idx == ADDR_W'(NUM_REGS - 1);
  // dump sequencer: every output is registered and updated on the state transition that needs it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      bus.rd_addr <= '0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= READ;
          bus.busy <= 1'b1;
          bus.rd_addr <= idx;
`ifdef REG_DUMP_CHECKSUM_EN
          sum <= '0;
`endif
        end
        READ: begin
          bus.out_data <= bus.rd_data;
          bus.out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          bus.out_last <= 1'b0;
          sum <= sum + bus.rd_data;
`else
          bus.out_last <= last_idx;
`endif
          state <= SEND;
        end
        SEND: if (hs) begin
          bus.out_valid <= 1'b0;
          bus.out_last <= 1'b0;
          if (last_idx) begin
            bus.rd_addr <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            bus.out_data <= sum;
            bus.out_valid <= 1'b1;
            bus.out_last <= 1'b1;
            state <= CSUM;
`else
            bus.done <= 1'b1;
            state <= DONE;
`endif
          end else begin
            idx <= idx + 1'b1;
            bus.rd_addr <= idx + 1'b1;
            state <= READ;
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: if (hs) begin
          bus.out_valid <= 1'b0;
          bus.out_last <= 1'b0;
          bus.done <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          idx <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl: scoreboard bench for reg_dump_ctrl with a behavioural 8x10 register file
module tb_reg_dump_ctrl;
  typedef logic [9:0] word_arr_t [8];
  typedef struct packed {logic [9:0] d; logic l;} exp_t;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int DONE_LAT = 18;
`else
  localparam int DONE_LAT = 17;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  reg_dump_ctrl_if bus();
  reg_dump_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  logic [9:0] regs [8];
  assign bus.rd_data = regs[bus.rd_addr];
  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_valid_cyc = -1;
  exp_t q[$];
  logic held_v = 1'b0;
  logic [9:0] held_d;
  logic held_l;
  word_arr_t pw, ev, ones;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push_exp(input word_arr_t w);
    logic [9:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s += w[i];
`ifdef REG_DUMP_CHECKSUM_EN
      q.push_back('{d: w[i], l: 1'b0});
`else
      q.push_back('{d: w[i], l: (i == 7)});
`endif
    end
`ifdef REG_DUMP_CHECKSUM_EN
    q.push_back('{d: s, l: 1'b1});
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_out_last"}, int'(bus.out_last), 0);
    check({tag, "_out_data"}, int'(bus.out_data), 0);
    check({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
  endtask

  // mode 0: ready high; 1: 3-cycle stalls; 2: start pulsed mid-dump; 3: r3 written early; 4: r3 written after capture
  task automatic run(input word_arr_t w, input int mode);
    int c0, d0, k;
    push_exp(w);
    @(posedge clk); #1;
    c0 = cyc;
    d0 = done_cnt;
    acc_cnt = 0;
    first_valid_cyc = -1;
    bus.start = 1'b1;
    bus.out_ready = (mode != 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      if (mode == 1) bus.out_ready = (k % 4 == 3);
      if (mode == 2) bus.start = (k == 5 || k == 6);
      if (mode == 3 && k == 0) regs[3] = 10'h3FF;
      if (mode == 4 && acc_cnt == 4) regs[3] = 10'h155;
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    check("dump_completes", int'(done_cnt != d0), 1);
    if (mode == 0) begin
      check("first_valid_latency", first_valid_cyc - c0, 2);
      check("done_latency", done_cyc - c0, DONE_LAT);
    end
    repeat (4) @(posedge clk);
    #1;
    check("single_done", done_cnt - d0, 1);
    check("words_outstanding", q.size(), 0);
    check("busy_after_dump", int'(bus.busy), 0);
    check("rd_addr_after_dump", int'(bus.rd_addr), 0);
    q.delete();
  endtask

  // monitor: pops the scoreboard on every handshake and checks stall stability and done timing
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) held_v = 1'b0;
    else begin
      if (held_v) begin
        check("stall_valid_held", int'(bus.out_valid), 1);
        check("stall_data_held", int'(bus.out_data), int'(held_d));
        check("stall_last_held", int'(bus.out_last), int'(held_l));
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("unexpected_word", int'(bus.out_data), -1);
        else begin
          e = q.pop_front();
          check("word_data", int'(bus.out_data), int'(e.d));
          check("word_last", int'(bus.out_last), int'(e.l));
          acc_cnt++;
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_d = bus.out_data;
      held_l = bus.out_last;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_words", q.size(), 0);
      end
    end
  end

  initial begin
    int k;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pw[i] = 10'(1 << i);
      ones[i] = 10'h3FF;
      regs[i] = pw[i];
    end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    run(pw, 0);
    run(pw, 1);
    push_exp(pw);
    @(posedge clk); #1;
    acc_cnt = 0;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (acc_cnt < 3 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_three_words", acc_cnt, 3);
    #2 reset = 1'b0;
    #1 check_all_zero("async_abort");
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    run(pw, 0);
    run(pw, 2);
    ev = pw;
    ev[3] = 10'h3FF;
    run(ev, 3);
    regs[3] = pw[3];
    run(pw, 4);
    regs[3] = pw[3];
    for (int i = 0; i < 8; i++) regs[i] = 10'h3FF;
    run(ones, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
